// File: rtl/rs_enc_mm.sv
// Multi-mode systematic RS encoder over GF(2^10): mode 0 = RS(528,514), mode 1 = RS(544,514).
// Gapped input, back-to-back codeword output, registered outputs with sop/eop framing and err pulse.
module rs_enc_mm #(
  parameter int SYM_W   = 10,
  parameter int K       = 514,
  parameter int NPAR_KR = 14,
  parameter int NPAR_KP = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode,
  input  logic             sop,
  input  logic             valid_in,
  input  logic [SYM_W-1:0] data_in,
  output logic             ready,
  output logic             valid_out,
  output logic [SYM_W-1:0] data_out,
  output logic             sop_out,
  output logic             eop_out,
  output logic             err
);
  localparam int CW = $clog2(K + 1);
  localparam int PW = $clog2(NPAR_KP);
  localparam logic [CW-1:0]    K_LAST  = CW'(K - 1);
  localparam logic [PW-1:0]    LAST_KR = PW'(NPAR_KR - 1);
  localparam logic [PW-1:0]    LAST_KP = PW'(NPAR_KP - 1);
  localparam logic [SYM_W-1:0] POLY_LO = SYM_W'(11'h409);
  localparam logic [SYM_W-1:0] ALPHA   = SYM_W'(2);
  localparam logic [SYM_W-1:0] ONE     = SYM_W'(1);

  typedef logic [NPAR_KP-1:0][SYM_W-1:0] regs_t;
  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  function automatic logic [SYM_W-1:0] gmul(input logic [SYM_W-1:0] a, input logic [SYM_W-1:0] b);
    logic [SYM_W-1:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < SYM_W; i++) begin
      if (b[i]) p = p ^ x;
      x = x[SYM_W-1] ? ((x << 1) ^ POLY_LO) : (x << 1);
    end
    return p;
  endfunction

  // Expands prod (x + alpha^i), i < p; the monic top term is dropped.
  function automatic regs_t gen_poly(input int p);
    logic [NPAR_KP:0][SYM_W-1:0] g;
    logic [SYM_W-1:0] root;
    regs_t res;
    g = '0;
    g[0] = ONE;
    root = ONE;
    for (int i = 0; i < p; i++) begin
      for (int j = NPAR_KP; j > 0; j--) g[j] = g[j-1] ^ gmul(g[j], root);
      g[0] = gmul(g[0], root);
      root = gmul(root, ALPHA);
    end
    res = '0;
    for (int j = 0; j < NPAR_KP; j++) if (j < p) res[j] = g[j];
    return res;
  endfunction

  localparam regs_t G_KR = gen_poly(NPAR_KR);
  localparam regs_t G_KP = gen_poly(NPAR_KP);

  state_t           state, state_nx;
  logic             mode_q, mode_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [PW-1:0]    pcnt, pcnt_nx;
  regs_t            r, r_nx, base, upd, shft;
  logic             use_mode, acc;
  logic [SYM_W-1:0] fb, do_nx;
  logic             vo_nx, so_nx, eo_nx, err_nx;

  assign ready    = (state != PARITY);
  assign acc      = valid_in && ready;
  // A sop symbol starts from a cleared LFSR with the freshly sampled mode.
  assign use_mode = sop ? mode : mode_q;
  assign base     = sop ? '0 : r;
  assign fb       = data_in ^ (use_mode ? base[NPAR_KP-1] : base[NPAR_KR-1]);

  always_comb begin
    upd  = '0;
    shft = '0;
    upd[0] = gmul(fb, use_mode ? G_KP[0] : G_KR[0]);
    for (int j = 1; j < NPAR_KP; j++) begin
      if (use_mode || j < NPAR_KR) upd[j] = base[j-1] ^ gmul(fb, use_mode ? G_KP[j] : G_KR[j]);
      if (mode_q || j < NPAR_KR) shft[j] = r[j-1];
    end
  end

  always_comb begin
    state_nx = state;
    mode_nx  = mode_q;
    cnt_nx   = cnt;
    pcnt_nx  = pcnt;
    r_nx     = r;
    vo_nx    = 1'b0;
    do_nx    = '0;
    so_nx    = 1'b0;
    eo_nx    = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE, DATA: if (acc) begin
        if (sop) begin
          state_nx = DATA;
          mode_nx  = mode;
          cnt_nx   = CW'(1);
          r_nx     = upd;
          vo_nx    = 1'b1;
          do_nx    = data_in;
          so_nx    = 1'b1;
          err_nx   = (state == DATA);
        end else if (state == IDLE) begin
          err_nx = 1'b1;
        end else begin
          r_nx   = upd;
          vo_nx  = 1'b1;
          do_nx  = data_in;
          cnt_nx = cnt + CW'(1);
          // cnt holds symbols already taken, so this one is the K-th
          if (cnt == K_LAST) begin
            state_nx = PARITY;
            pcnt_nx  = '0;
          end
        end
      end
      PARITY: begin
        vo_nx   = 1'b1;
        do_nx   = mode_q ? r[NPAR_KP-1] : r[NPAR_KR-1];
        r_nx    = shft;
        pcnt_nx = pcnt + PW'(1);
        if (pcnt == (mode_q ? LAST_KP : LAST_KR)) begin
          eo_nx    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      cnt       <= '0;
      pcnt      <= '0;
      r         <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
      err       <= 1'b0;
    end else begin
      mode_q    <= mode_nx;
      cnt       <= cnt_nx;
      pcnt      <= pcnt_nx;
      r         <= r_nx;
      valid_out <= vo_nx;
      data_out  <= do_nx;
      sop_out   <= so_nx;
      eop_out   <= eo_nx;
      err       <= err_nx;
    end
  end
endmodule

// File: tb/tb_rs_enc_mm.sv
// Directed bench for rs_enc_mm: syndrome-checked codewords, generator-polynomial impulse response,
// gapped back-to-back framing, protocol errors and mid-parity reset.
module tb_rs_enc_mm;
  localparam int K = 514;

  logic       clk = 1'b0, rst = 1'b1, mode = 1'b0, sop = 1'b0, valid_in = 1'b0;
  logic [9:0] data_in = '0;
  logic       ready, valid_out, sop_out, eop_out, err;
  logic [9:0] data_out;

  int n_assert = 0, n_fail = 0;
  int cyc = 0, err_seen = 0, rdy_low = 0;
  logic [9:0] dat_q[$];
  bit         sop_q[$], eop_q[$];
  int         cyc_q[$];

  logic [9:0] msg [K];
  logic [9:0] ref_par [30];
  logic [9:0] last_par [30];
  logic [9:0] par_kp [30];
  logic [9:0] par_kr [14];
  logic [9:0] g_kp [30];
  logic [9:0] g_kr [14];
  logic [9:0] gtmp [31];

  always #5 clk = ~clk;

  rs_enc_mm dut (
    .clk(clk), .rst(rst), .mode(mode), .sop(sop), .valid_in(valid_in), .data_in(data_in),
    .ready(ready), .valid_out(valid_out), .data_out(data_out), .sop_out(sop_out),
    .eop_out(eop_out), .err(err)
  );

  always @(negedge clk) begin
    cyc++;
    if (valid_out) begin
      dat_q.push_back(data_out);
      sop_q.push_back(sop_out);
      eop_q.push_back(eop_out);
      cyc_q.push_back(cyc);
    end
    if (err) err_seen++;
    if (!ready) rdy_low++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [9:0] gf_mul(input logic [9:0] a, input logic [9:0] b);
    logic [19:0] p;
    p = '0;
    for (int i = 0; i < 10; i++) if (b[i]) p = p ^ (20'(a) << i);
    for (int i = 19; i >= 10; i--) if (p[i]) p = p ^ (20'h409 << (i - 10));
    return p[9:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic calc_g(input int p);
    logic [9:0] root;
    for (int j = 0; j < 31; j++) gtmp[j] = '0;
    gtmp[0] = 10'd1;
    root = 10'd1;
    for (int i = 0; i < p; i++) begin
      for (int j = i + 1; j > 0; j--) gtmp[j] = gtmp[j-1] ^ gf_mul(gtmp[j], root);
      gtmp[0] = gf_mul(gtmp[0], root);
      root = gf_mul(root, 10'd2);
    end
  endtask

  task automatic set_msg(input int kind);
    for (int i = 0; i < K; i++)
      case (kind)
        0:       msg[i] = 10'((i * 97 + 13) ^ (i >> 2));
        1:       msg[i] = '0;
        default: msg[i] = (i == K - 1) ? 10'd1 : 10'd0;
      endcase
  endtask

  task automatic send_cw(input bit md, input int gap_pct, input int nsym);
    int g;
    for (int i = 0; i < nsym; i++) begin
      if (i > 0)
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
          valid_in = 1'b0;
          @(posedge clk); #1;
        end
      valid_in = 1'b1;
      sop      = (i == 0);
      mode     = (i == 0) ? md : ~md;
      data_in  = msg[i];
      g = 0;
      while (!ready && g < 100) begin
        @(posedge clk); #1;
        g++;
      end
      if (i == 0) chk("send.ready_wait", 32'(ready), 32'd1);
      @(posedge clk); #1;
    end
    valid_in = 1'b0;
    sop      = 1'b0;
  endtask

  task automatic wait_out(input int target, input string tag);
    int g;
    g = 0;
    while (dat_q.size() < target && g < 3000) begin
      @(posedge clk); #1;
      g++;
    end
    chk({tag, ".timeout"}, 32'(dat_q.size() >= target), 32'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_cw(input int off, input int p, input string tag, input bit use_ref);
    int n, bad, nflag, nsyn;
    logic [9:0] a, s;
    n = K + p;
    chk({tag, ".len"}, 32'(dat_q.size() >= off + n), 32'd1);
    if (dat_q.size() < off + n) return;
    bad = 0;
    for (int k = 0; k < K; k++) if (dat_q[off+k] !== msg[k]) bad++;
    chk({tag, ".data_mismatches"}, bad, 0);
    chk({tag, ".sop_first"}, 32'(sop_q[off]), 32'd1);
    chk({tag, ".eop_last"}, 32'(eop_q[off+n-1]), 32'd1);
    nflag = 0;
    for (int k = 1; k < n; k++) if (sop_q[off+k]) nflag++;
    for (int k = 0; k < n - 1; k++) if (eop_q[off+k]) nflag++;
    chk({tag, ".stray_flags"}, nflag, 0);
    nsyn = 0;
    a = 10'd1;
    for (int i = 0; i < p; i++) begin
      s = '0;
      for (int k = 0; k < n; k++) s = gf_mul(s, a) ^ dat_q[off+k];
      if (s !== 10'd0) nsyn++;
      a = gf_mul(a, 10'd2);
    end
    chk({tag, ".nonzero_syndromes"}, nsyn, 0);
    for (int k = 0; k < p; k++) last_par[k] = dat_q[off+K+k];
    if (use_ref) begin
      bad = 0;
      for (int k = 0; k < p; k++) if (dat_q[off+K+k] !== ref_par[k]) bad++;
      chk({tag, ".parity_mismatches"}, bad, 0);
    end
  endtask

  initial begin
    int base, rl0, e0, sz;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.valid_out", 32'(valid_out), 32'd0);
    chk("reset.data_out", 32'(data_out), 32'd0);
    chk("reset.sop_out", 32'(sop_out), 32'd0);
    chk("reset.eop_out", 32'(eop_out), 32'd0);
    chk("reset.err", 32'(err), 32'd0);
    chk("reset.ready", 32'(ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    calc_g(14);
    for (int j = 0; j < 14; j++) g_kr[j] = gtmp[j];
    calc_g(30);
    for (int j = 0; j < 30; j++) g_kp[j] = gtmp[j];

    // KP4 gapless reference run
    set_msg(0);
    base = dat_q.size(); rl0 = rdy_low; e0 = err_seen;
    send_cw(1'b1, 0, K);
    wait_out(base + 544, "kp4");
    check_cw(base, 30, "kp4", 1'b0);
    for (int k = 0; k < 30; k++) par_kp[k] = last_par[k];
    chk("kp4.ready_low_cycles", rdy_low - rl0, 30);
    chk("kp4.err_pulses", err_seen - e0, 0);

    // KR4 gapless reference run, same message
    base = dat_q.size(); rl0 = rdy_low;
    send_cw(1'b0, 0, K);
    wait_out(base + 528, "kr4");
    check_cw(base, 14, "kr4", 1'b0);
    for (int k = 0; k < 14; k++) par_kr[k] = last_par[k];
    chk("kr4.ready_low_cycles", rdy_low - rl0, 14);

    // All-zero message: all parity zero
    set_msg(1);
    for (int k = 0; k < 30; k++) ref_par[k] = '0;
    base = dat_q.size();
    send_cw(1'b1, 0, K);
    wait_out(base + 544, "zero_kp4");
    check_cw(base, 30, "zero_kp4", 1'b1);
    base = dat_q.size();
    send_cw(1'b0, 0, K);
    wait_out(base + 528, "zero_kr4");
    check_cw(base, 14, "zero_kr4", 1'b1);

    // Single 0x001 at the last message position: parity is g_{P-1}..g_0
    set_msg(2);
    for (int k = 0; k < 14; k++) ref_par[k] = g_kr[13-k];
    base = dat_q.size();
    send_cw(1'b0, 0, K);
    wait_out(base + 528, "one_kr4");
    check_cw(base, 14, "one_kr4", 1'b1);
    // g_13 is the sum of alpha^0..alpha^13, worked by hand
    if (dat_q.size() > base + K) chk("one_kr4.g13_hand", 32'(dat_q[base+K]), 32'h388);
    for (int k = 0; k < 30; k++) ref_par[k] = g_kp[29-k];
    base = dat_q.size();
    send_cw(1'b1, 0, K);
    wait_out(base + 544, "one_kp4");
    check_cw(base, 30, "one_kp4", 1'b1);

    // Gapped input, three back-to-back codewords, modes 1,0,1
    set_msg(0);
    base = dat_q.size(); e0 = err_seen;
    send_cw(1'b1, 30, K);
    send_cw(1'b0, 30, K);
    send_cw(1'b1, 30, K);
    wait_out(base + 544 + 528 + 544, "b2b");
    for (int k = 0; k < 30; k++) ref_par[k] = par_kp[k];
    check_cw(base, 30, "b2b.cw0", 1'b1);
    check_cw(base + 1072, 30, "b2b.cw2", 1'b1);
    for (int k = 0; k < 14; k++) ref_par[k] = par_kr[k];
    check_cw(base + 544, 14, "b2b.cw1", 1'b1);
    if (dat_q.size() >= base + 1616) begin
      chk("b2b.gap_cw0_cw1", cyc_q[base+544] - cyc_q[base+543], 1);
      chk("b2b.gap_cw1_cw2", cyc_q[base+1072] - cyc_q[base+1071], 1);
    end
    chk("b2b.err_pulses", err_seen - e0, 0);

    // Second sop at symbol 200 aborts the KP4 codeword; KR4 codeword follows
    base = dat_q.size(); e0 = err_seen;
    send_cw(1'b1, 0, 200);
    send_cw(1'b0, 0, K);
    wait_out(base + 200 + 528, "abort");
    chk("abort.err_pulses", err_seen - e0, 1);
    chk("abort.out_len", dat_q.size() - base, 728);
    check_cw(base + 200, 14, "abort.cw", 1'b1);

    // Stray symbol in IDLE
    base = dat_q.size(); e0 = err_seen;
    valid_in = 1'b1; sop = 1'b0; data_in = 10'h155;
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("stray.err_pulses", err_seen - e0, 1);
    chk("stray.no_output", dat_q.size() - base, 0);

    // Reset while parity symbol 10 of a KP4 codeword is on the output
    send_cw(1'b1, 0, K);
    repeat (11) @(posedge clk);
    #1;
    chk("rst.pre_valid", 32'(valid_out), 32'd1);
    chk("rst.pre_parity10", 32'(data_out), 32'(par_kp[10]));
    rst = 1'b1;
    #1;
    chk("rst.valid_out", 32'(valid_out), 32'd0);
    chk("rst.data_out", 32'(data_out), 32'd0);
    chk("rst.eop_out", 32'(eop_out), 32'd0);
    chk("rst.ready", 32'(ready), 32'd1);
    sz = dat_q.size();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    chk("rst.no_tail", dat_q.size() - sz, 0);
    base = dat_q.size();
    send_cw(1'b1, 0, K);
    wait_out(base + 544, "post_rst");
    for (int k = 0; k < 30; k++) ref_par[k] = par_kp[k];
    check_cw(base, 30, "post_rst", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
